// File: rtl/ram_line_master.sv
// Requesting end of the byte-serial RAM port: moves one cache line per
// request, LSB byte first, with an ack timeout on every wait for the responder.
module ram_line_master #(
  parameter int ADDR_SIZE   = 12,
  parameter int WORD_SIZE   = 8,
  parameter int DATA_SIZE   = 128,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                 ram_clk,
  input  logic                 ram_rst,
  input  logic                 req_valid,
  input  logic                 req_we,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [DATA_SIZE-1:0] req_wline,
  output logic                 req_ready,
  output logic                 resp_valid,
  output logic                 resp_err,
  output logic [DATA_SIZE-1:0] resp_rline,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic                 ram_avalid,
  output logic                 ram_rnw,
  output logic [WORD_SIZE-1:0] ram_wdata,
  input  logic [WORD_SIZE-1:0] ram_rdata,
  input  logic                 ram_ack
);

  localparam int BEATS = DATA_SIZE / WORD_SIZE;
  localparam int CW    = $clog2(BEATS + 1);
  localparam int TW    = $clog2(ACK_TIMEOUT + 1);

  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic [TW-1:0] TMO       = TW'(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    WR_SEND,
    WR_ACK,
    RD_WAIT,
    RD_RECV,
    DONE
  } state_t;

  state_t               state;
  logic [DATA_SIZE-1:0] line_q;
  logic [CW-1:0]        beat_q;
  logic [TW-1:0]        tmr_q;

  logic [TW-1:0]        tmr_inc;
  logic [DATA_SIZE-1:0] line_in;
  logic                 ack_wait;
  logic                 tmo;
  logic                 last;
  logic                 fin;

  always_comb begin
    tmr_inc  = tmr_q + TW'(1);
    line_in  = {ram_rdata, line_q[DATA_SIZE-1:WORD_SIZE]};
    ack_wait = (state == WR_ACK) || (state == RD_WAIT)
            || (state == RD_RECV);
    tmo      = ack_wait && !ram_ack && (tmr_inc == TMO);
    last     = ram_ack && ((state == WR_ACK)
            || ((state == RD_RECV) && (beat_q == LAST_BEAT)));
    fin      = tmo || last;
  end

  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rline <= '0;
      ram_addr   <= '0;
      ram_avalid <= 1'b0;
      ram_rnw    <= 1'b0;
      ram_wdata  <= '0;
      line_q     <= '0;
      beat_q     <= '0;
      tmr_q      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready  <= 1'b0;
            line_q     <= req_wline;
            ram_addr   <= req_addr;
            ram_rnw    <= ~req_we;
            ram_avalid <= 1'b1;
            beat_q     <= '0;
            tmr_q      <= '0;
            if (req_we) begin
              ram_wdata <= req_wline[WORD_SIZE-1:0];
              state     <= WR_SEND;
            end else begin
              state     <= RD_WAIT;
            end
          end
        end
        WR_SEND: begin
          line_q    <= line_q >> WORD_SIZE;
          ram_wdata <= line_q[2*WORD_SIZE-1:WORD_SIZE];
          if (beat_q == LAST_BEAT) begin
            tmr_q <= '0;
            state <= WR_ACK;
          end else begin
            beat_q <= beat_q + CW'(1);
          end
        end
        WR_ACK: begin
          if (!ram_ack) tmr_q <= tmr_inc;
        end
        RD_WAIT: begin
          if (ram_ack) begin
            line_q <= line_in;
            beat_q <= CW'(1);
            tmr_q  <= '0;
            state  <= RD_RECV;
          end else begin
            tmr_q <= tmr_inc;
          end
        end
        RD_RECV: begin
          if (ram_ack) begin
            line_q <= line_in;
            tmr_q  <= '0;
            if (beat_q != LAST_BEAT) beat_q <= beat_q + CW'(1);
          end else begin
            tmr_q <= tmr_inc;
          end
        end
        DONE: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // completion overrides the per-state next state chosen above
      if (fin) begin
        state      <= DONE;
        ram_avalid <= 1'b0;
        resp_valid <= 1'b1;
        resp_err   <= tmo;
        if (last && (state == RD_RECV)) resp_rline <= line_in;
      end
    end
  end

endmodule

// File: tb/tb_ram_line_master.sv
// Bench for ram_line_master: behavioural RAM responder, directed table,
// hand-written corner sequences and a randomized run against a line model.
module tb_ram_line_master;

  logic         ram_clk;
  logic         ram_rst;
  logic         req_valid;
  logic         req_we;
  logic [11:0]  req_addr;
  logic [127:0] req_wline;
  logic         req_ready;
  logic         resp_valid;
  logic         resp_err;
  logic [127:0] resp_rline;
  logic [11:0]  ram_addr;
  logic         ram_avalid;
  logic         ram_rnw;
  logic [7:0]   ram_wdata;
  logic [7:0]   ram_rdata;
  logic         ram_ack;

  ram_line_master dut (
    .ram_clk    (ram_clk),
    .ram_rst    (ram_rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wline  (req_wline),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rline (resp_rline),
    .ram_addr   (ram_addr),
    .ram_avalid (ram_avalid),
    .ram_rnw    (ram_rnw),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .ram_ack    (ram_ack)
  );

  initial ram_clk = 1'b0;
  always #5 ram_clk = ~ram_clk;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  function automatic void check(string name, logic [127:0] act,
                                logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // responder configuration and storage
  logic [127:0] ram_mem [logic [11:0]];
  logic [127:0] model_mem [logic [11:0]];
  int  cfg_idle, cfg_dly, cfg_stall_at, cfg_stall_len, rsp_extra;
  bit  cfg_never, cfg_rnd;
  logic rsp_av_prev;

  task automatic serve();
    logic [127:0] ln;
    logic [11:0]  a;
    bit           ok;
    a  = ram_addr;
    ok = 1'b1;
    rsp_extra = 0;
    ln = '0;
    if (!ram_rnw) begin
      ln[7:0] = ram_wdata;
      for (int k = 1; k < 16; k++) begin
        ram_ack = cfg_rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge ram_clk);
        if (!ram_avalid) begin ok = 1'b0; break; end
        ln[8*k +: 8] = ram_wdata;
      end
      ram_ack = 1'b0;
      if (ok) begin
        @(negedge ram_clk);
        if (!ram_avalid) ok = 1'b0;
      end
      if (ok && !cfg_never) begin
        for (int i = 0; i < cfg_dly; i++) begin
          @(negedge ram_clk);
          if (!ram_avalid) begin ok = 1'b0; break; end
        end
        if (ok) begin
          ram_ack = 1'b1;
          @(negedge ram_clk);
          ram_ack = 1'b0;
          ram_mem[a] = ln;
        end
      end
    end else if (!cfg_never) begin
      ln = ram_mem.exists(a) ? ram_mem[a] : '0;
      for (int i = 0; i < cfg_idle; i++) begin
        ram_ack = 1'b0;
        @(negedge ram_clk);
        if (!ram_avalid) begin ok = 1'b0; break; end
      end
      for (int b = 0; b < 16 && ok; b++) begin
        int n;
        n = (b == cfg_stall_at) ? cfg_stall_len : 0;
        if (cfg_rnd && ($urandom_range(0, 3) == 0)) begin
          int e;
          e = int'($urandom_range(1, 3));
          rsp_extra += e;
          n += e;
        end
        for (int s = 0; s < n; s++) begin
          ram_ack = 1'b0;
          @(negedge ram_clk);
          if (!ram_avalid) begin ok = 1'b0; break; end
        end
        if (!ok) break;
        ram_ack   = 1'b1;
        ram_rdata = ln[8*b +: 8];
        @(negedge ram_clk);
        if (!ram_avalid && b != 15) ok = 1'b0;
      end
      ram_ack = 1'b0;
    end
    for (int i = 0; i < 300 && ram_avalid; i++) @(negedge ram_clk);
    ram_ack = 1'b0;
  endtask

  initial begin : responder
    ram_ack     = 1'b0;
    ram_rdata   = '0;
    rsp_av_prev = 1'b0;
    forever begin
      @(negedge ram_clk);
      if (!ram_rst && ram_avalid && !rsp_av_prev) serve();
      rsp_av_prev = ram_avalid;
    end
  end

  // bus protocol monitor
  logic        mon_av = 1'b0;
  logic [12:0] mon_ar = '0;
  int          low_cnt = 100;

  always @(negedge ram_clk) begin
    if (resp_valid) pulses++;
    if (ram_avalid && mon_av)
      check("addr_rnw_stable", 128'({ram_rnw, ram_addr}), 128'(mon_ar));
    if (ram_avalid && !mon_av)
      check("avalid_gap_ge2", 128'(low_cnt >= 2), 128'(1));
    low_cnt = ram_avalid ? 0 : low_cnt + 1;
    mon_av  = ram_avalid;
    mon_ar  = {ram_rnw, ram_addr};
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic we, input logic [11:0] a,
                       input logic [127:0] l);
    check("ready_before_req", 128'(req_ready), 128'(1));
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wline = l;
    @(negedge ram_clk);
    req_valid = 1'b0;
    check("avalid_after_E0", 128'(ram_avalid), 128'(1));
    check("rnw_after_E0", 128'(ram_rnw), 128'(!we));
    check("addr_after_E0", 128'(ram_addr), 128'(a));
  endtask

  task automatic wait_resp(output int lat, output logic err,
                           output logic [127:0] rl);
    lat = 0;
    while (!resp_valid && lat < 300) begin
      @(negedge ram_clk);
      lat++;
    end
    check("resp_seen", 128'(resp_valid), 128'(1));
    err = resp_err;
    rl  = resp_rline;
    @(negedge ram_clk);
    check("resp_one_cycle", 128'(resp_valid), 128'(0));
    check("ready_after_done", 128'(req_ready), 128'(1));
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_ctl"},
          128'({req_ready, resp_valid, resp_err, ram_avalid, ram_rnw}),
          128'(5'b10000));
    check({tag, "_rline"}, resp_rline, '0);
    check({tag, "_addr"}, 128'(ram_addr), '0);
    check({tag, "_wdata"}, 128'(ram_wdata), '0);
  endtask

  typedef struct {
    logic         we;
    logic [11:0]  addr;
    logic [127:0] line;
    int           idle;
    int           dly;
    int           stall_at;
    int           stall_len;
    bit           never;
    logic         exp_err;
    int           exp_lat;
    logic [127:0] exp_line;
  } vec_t;

  localparam logic [127:0] L_INC = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] L_A0  = 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0;
  localparam logic [127:0] L_ST  = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] L_DB  = 128'hDEADBEEFCAFEF00D0BADC0DE12345678;
  localparam logic [127:0] L_55  = 128'h5555AAAA3333CCCC0F0FF0F01E1EE1E1;

  vec_t tbl [7];

  initial begin : stim
    int           lat;
    logic         err;
    logic [127:0] rl;
    int           p0;

    tbl[0] = '{1'b1, 12'h3A5, L_INC, 0, 0, -1, 0, 1'b0, 1'b0, 17, L_INC};
    tbl[1] = '{1'b0, 12'h123, L_A0,  3, 0, -1, 0, 1'b0, 1'b0, 19, L_A0};
    tbl[2] = '{1'b0, 12'h124, L_ST,  1, 0,  8, 5, 1'b0, 1'b0, 22, L_ST};
    tbl[3] = '{1'b0, 12'h125, L_DB,  0, 0, -1, 0, 1'b1, 1'b1, 64, L_ST};
    tbl[4] = '{1'b1, 12'h3A6, L_DB,  0, 3, -1, 0, 1'b0, 1'b0, 20, L_DB};
    tbl[5] = '{1'b1, 12'h3A7, L_55,  0, 0, -1, 0, 1'b1, 1'b1, 80, L_ST};
    tbl[6] = '{1'b0, 12'h126, L_55, 63, 0, -1, 0, 1'b0, 1'b0, 79, L_55};

    cfg_idle = 0; cfg_dly = 0; cfg_stall_at = -1; cfg_stall_len = 0;
    cfg_never = 1'b0; cfg_rnd = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wline = '0;
    ram_rst = 1'b1;
    repeat (3) @(negedge ram_clk);
    check_reset_vals("reset");
    ram_rst = 1'b0;
    @(negedge ram_clk);

    for (int i = 0; i < 7; i++) begin
      cfg_idle      = tbl[i].idle;
      cfg_dly       = tbl[i].dly;
      cfg_stall_at  = tbl[i].stall_at;
      cfg_stall_len = tbl[i].stall_len;
      cfg_never     = tbl[i].never;
      if (!tbl[i].we && !tbl[i].never) ram_mem[tbl[i].addr] = tbl[i].line;
      p0 = pulses;
      issue(tbl[i].we, tbl[i].addr, tbl[i].line);
      wait_resp(lat, err, rl);
      check($sformatf("t%0d_latency", i), 128'(lat), 128'(tbl[i].exp_lat));
      check($sformatf("t%0d_err", i), 128'(err), 128'(tbl[i].exp_err));
      check($sformatf("t%0d_pulses", i), 128'(pulses - p0), 128'(1));
      if (tbl[i].we && !tbl[i].exp_err)
        check($sformatf("t%0d_stored", i), ram_mem[tbl[i].addr],
              tbl[i].exp_line);
      else
        check($sformatf("t%0d_rline", i), rl, tbl[i].exp_line);
    end
    cfg_never = 1'b0; cfg_stall_at = -1; cfg_stall_len = 0;
    cfg_idle = 0; cfg_dly = 0;

    // back-to-back: req_valid held high across the write
    ram_mem[12'h0A1] = L_A0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h0A0; req_wline = L_DB;
    @(negedge ram_clk);
    req_we = 1'b0; req_addr = 12'h0A1;
    check("b2b_wr_rnw", 128'(ram_rnw), 128'(0));
    check("b2b_wr_addr", 128'(ram_addr), 128'(12'h0A0));
    wait_resp(lat, err, rl);
    check("b2b_wr_latency", 128'(lat), 128'(17));
    check("b2b_wr_err", 128'(err), 128'(0));
    check("b2b_rd_not_yet", 128'(ram_avalid), 128'(0));
    @(negedge ram_clk);
    req_valid = 1'b0;
    check("b2b_rd_avalid", 128'(ram_avalid), 128'(1));
    check("b2b_rd_rnw", 128'(ram_rnw), 128'(1));
    check("b2b_rd_addr", 128'(ram_addr), 128'(12'h0A1));
    wait_resp(lat, err, rl);
    check("b2b_rd_latency", 128'(lat), 128'(16));
    check("b2b_rd_err", 128'(err), 128'(0));
    check("b2b_rd_rline", rl, L_A0);
    check("b2b_wr_stored", ram_mem[12'h0A0], L_DB);

    // reset in the middle of a write burst
    p0 = pulses;
    issue(1'b1, 12'h055, L_INC);
    repeat (8) @(negedge ram_clk);
    ram_rst = 1'b1;
    @(negedge ram_clk);
    check_reset_vals("midrst");
    ram_rst = 1'b0;
    repeat (3) @(negedge ram_clk);
    check("midrst_no_pulse", 128'(pulses - p0), 128'(0));
    check("midrst_no_store", 128'(ram_mem.exists(12'h055)), 128'(0));
    issue(1'b0, 12'h0A1, '0);
    wait_resp(lat, err, rl);
    check("midrst_rd_err", 128'(err), 128'(0));
    check("midrst_rd_rline", rl, L_A0);

    // randomized traffic against a line-level model
    cfg_rnd = 1'b1;
    for (int t = 0; t < 40; t++) begin
      logic         we;
      logic [11:0]  a;
      logic [127:0] l;
      int           exp_lat;
      we = 1'($urandom_range(0, 1));
      a  = 12'h800 + 12'($urandom_range(0, 3));
      l  = {$urandom, $urandom, $urandom, $urandom};
      cfg_idle      = int'($urandom_range(0, 5));
      cfg_dly       = int'($urandom_range(0, 5));
      cfg_stall_at  = int'($urandom_range(0, 15));
      cfg_stall_len = int'($urandom_range(0, 4));
      issue(we, a, l);
      wait_resp(lat, err, rl);
      exp_lat = we ? 17 + cfg_dly : cfg_idle + 16 + cfg_stall_len + rsp_extra;
      check($sformatf("r%0d_latency", t), 128'(lat), 128'(exp_lat));
      check($sformatf("r%0d_err", t), 128'(err), 128'(0));
      if (we) begin
        model_mem[a] = l;
        check($sformatf("r%0d_stored", t), ram_mem[a], l);
      end else begin
        check($sformatf("r%0d_rline", t), rl,
              model_mem.exists(a) ? model_mem[a] : '0);
      end
      repeat ($urandom_range(0, 2)) @(negedge ram_clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
